// File: rtl/acx_mlp_pkg.sv
// Shared helpers for the MLP integer multiply-add primitives.
// Widths and lane offsets live here so every instance sizes its datapath consistently.
package acx_mlp_pkg;

  localparam int unsigned INT_SIZE_MIN = 3;
  localparam int unsigned INT_SIZE_MAX = 16;
  localparam int unsigned NUM_MULT_MAX = 16;

  // Exact width of one lane product of two (int_size+1)-bit extended operands.
  function automatic int unsigned prod_width(input int unsigned isz);
    return 2 * isz + 2;
  endfunction

  // Full-precision width of the sum of all lane products.
  function automatic int unsigned sum_width(input int unsigned isz, input int unsigned nm);
    return prod_width(isz) + $clog2(nm);
  endfunction

  // Bit offset of lane idx within a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned isz);
    return idx * isz;
  endfunction

endpackage

// File: rtl/acx_mult_lane.sv
// One multiply lane: operands extended to int_size+1 bits (sign or zero per flag),
// product kept at full exact width.
module acx_mult_lane
  import acx_mlp_pkg::*;
#(
  parameter int unsigned int_size       = 8,
  parameter int unsigned int_unsigned_a = 0,
  parameter int unsigned int_unsigned_b = 0
) (
  input  logic                                    [int_size-1:0] i_a,
  input  logic                                    [int_size-1:0] i_b,
  output logic signed [prod_width(int_size)-1:0]                 o_prod
);

  localparam int unsigned PW = prod_width(int_size);

  logic signed [int_size:0] a_ext;
  logic signed [int_size:0] b_ext;

  always_comb begin
    a_ext = {((int_unsigned_a != 0) ? 1'b0 : i_a[int_size-1]), i_a};
    b_ext = {((int_unsigned_b != 0) ? 1'b0 : i_b[int_size-1]), i_b};
  end

  // Both operands widened to the product width first so the multiply is exact.
  always_comb begin
    o_prod = PW'(a_ext) * PW'(b_ext);
  end

endmodule

// File: rtl/acx_int_mult_add.sv
// ACX_INT_MULT_ADD: num_mult-lane integer dot product with optional input registers,
// optional accumulator and up to two output pipeline stages.
module acx_int_mult_add
  import acx_mlp_pkg::*;
#(
  parameter int unsigned int_size       = 8,
  parameter int unsigned num_mult       = 8,
  parameter int unsigned int_unsigned_a = 0,
  parameter int unsigned int_unsigned_b = 0,
  parameter int unsigned accumulate     = 0,
  parameter int unsigned in_reg_enable  = 0,
  parameter int unsigned pipeline_regs  = 0,
  parameter int unsigned dout_size      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_in_reg_rstn,
  input  logic                         i_pipeline_rstn,
  input  logic [int_size*num_mult-1:0] i_din_a,
  input  logic [int_size*num_mult-1:0] i_din_b,
  input  logic                         i_in_reg_a_ce,
  input  logic                         i_in_reg_b_ce,
  input  logic                         i_pipeline_ce,
  input  logic                         i_load,
  output logic [dout_size-1:0]         o_dout
);

  localparam int unsigned BUS = int_size * num_mult;
  localparam int unsigned PW  = prod_width(int_size);
  localparam int unsigned SW  = sum_width(int_size, num_mult);

  logic [BUS-1:0]        a_q;
  logic [BUS-1:0]        b_q;
  logic signed [PW-1:0]  prod [num_mult];
  logic signed [SW-1:0]  sum_full;
  logic [dout_size-1:0]  sum_d;
  logic [dout_size-1:0]  acc_out;

  // Controls are legitimately ignored in the fully combinational configuration.
  logic unused_ctrl;
  assign unused_ctrl = ^{i_clk, i_in_reg_rstn, i_pipeline_rstn, i_in_reg_a_ce,
                         i_in_reg_b_ce, i_pipeline_ce, i_load};

  // ---------------------------------------------------------------- input registers
  if (in_reg_enable != 0) begin : g_in_reg
    always_ff @(posedge i_clk or negedge i_in_reg_rstn) begin
      if (!i_in_reg_rstn) begin
        a_q <= '0;
      end else if (i_in_reg_a_ce) begin
        a_q <= i_din_a;
      end
    end

    always_ff @(posedge i_clk or negedge i_in_reg_rstn) begin
      if (!i_in_reg_rstn) begin
        b_q <= '0;
      end else if (i_in_reg_b_ce) begin
        b_q <= i_din_b;
      end
    end
  end else begin : g_in_bypass
    assign a_q = i_din_a;
    assign b_q = i_din_b;
  end

  // ---------------------------------------------------------------- multiply lanes
  for (genvar k = 0; k < num_mult; k++) begin : g_lane
    localparam int unsigned LSB = lane_lsb(k, int_size);

    acx_mult_lane #(
      .int_size       (int_size),
      .int_unsigned_a (int_unsigned_a),
      .int_unsigned_b (int_unsigned_b)
    ) u_lane (
      .i_a    (a_q[LSB +: int_size]),
      .i_b    (b_q[LSB +: int_size]),
      .o_prod (prod[k])
    );
  end

  // ---------------------------------------------------------------- adder tree
  always_comb begin
    sum_full = '0;
    for (int unsigned k = 0; k < num_mult; k++) begin
      sum_full = sum_full + SW'(prod[k]);
    end
  end

  // Signed resize: sign-extends when dout_size > SW, wraps when narrower.
  assign sum_d = dout_size'(sum_full);

  // ---------------------------------------------------------------- accumulator
  if (accumulate != 0) begin : g_acc
    logic [dout_size-1:0] acc_q;

    always_ff @(posedge i_clk or negedge i_pipeline_rstn) begin
      if (!i_pipeline_rstn) begin
        acc_q <= '0;
      end else if (i_pipeline_ce) begin
        acc_q <= i_load ? sum_d : acc_q + sum_d;
      end
    end

    assign acc_out = acc_q;
  end else begin : g_no_acc
    assign acc_out = sum_d;
  end

  // ---------------------------------------------------------------- output pipeline
  if (pipeline_regs != 0) begin : g_pipe
    logic [dout_size-1:0] stage [pipeline_regs];

    always_ff @(posedge i_clk or negedge i_pipeline_rstn) begin
      if (!i_pipeline_rstn) begin
        for (int unsigned i = 0; i < pipeline_regs; i++) begin
          stage[i] <= '0;
        end
      end else if (i_pipeline_ce) begin
        stage[0] <= acc_out;
        for (int unsigned i = 1; i < pipeline_regs; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign o_dout = stage[pipeline_regs-1];
  end else begin : g_no_pipe
    assign o_dout = acc_out;
  end

endmodule

// File: tb/tb_acx_int_mult_add.sv
// Bench for acx_int_mult_add: several parameterisations share one stimulus bus and
// are checked against a plain-arithmetic dot-product model.
module tb_acx_int_mult_add;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_rstn, pipe_rstn, a_ce, b_ce, p_ce, load;
  logic [63:0] din_a, din_b;
  logic [31:0] o_comb, o_uns, o_ua, o_pipe, o_acc;
  logic [7:0]  o_acc8;

  int total = 0;
  int bad   = 0;

  acx_int_mult_add u_comb (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_comb));

  acx_int_mult_add #(.int_unsigned_a(1), .int_unsigned_b(1)) u_uns (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_uns));

  acx_int_mult_add #(.int_unsigned_a(1)) u_ua (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_ua));

  acx_int_mult_add #(.in_reg_enable(1), .pipeline_regs(1)) u_pipe (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_pipe));

  acx_int_mult_add #(.accumulate(1)) u_acc (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_acc));

  acx_int_mult_add #(.accumulate(1), .dout_size(8)) u_acc8 (
    .i_clk(clk), .i_in_reg_rstn(in_rstn), .i_pipeline_rstn(pipe_rstn),
    .i_din_a(din_a), .i_din_b(din_b), .i_in_reg_a_ce(a_ce), .i_in_reg_b_ce(b_ce),
    .i_pipeline_ce(p_ce), .i_load(load), .o_dout(o_acc8));

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    int          exp_s;
    int          exp_u;
    int          exp_ua;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [63:0] splat(input int v);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(v);
    return r;
  endfunction

  // Reference dot product: interpret each byte as an integer, multiply, sum.
  function automatic longint dot(input logic [63:0] a, input logic [63:0] b,
                                 input bit ua, input bit ub);
    longint s = 0;
    for (int k = 0; k < 8; k++) begin
      longint x = longint'(a[k*8 +: 8]);
      longint y = longint'(b[k*8 +: 8]);
      if (!ua && x >= 128) x = x - 256;
      if (!ub && y >= 128) y = y - 256;
      s = s + x * y;
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_rstn   = 1'b0;
    pipe_rstn = 1'b0;
    #1;
    in_rstn   = 1'b1;
    pipe_rstn = 1'b1;
  endtask

  initial begin
    logic [63:0] mixed;
    longint      m;
    longint      s;

    for (int k = 0; k < 8; k++) mixed[k*8 +: 8] = 8'(k - 3);
    tbl[0] = '{"neg128_sq",  splat(-128), splat(-128), 131072,  131072, -131072};
    tbl[1] = '{"p127_n128",  splat(127),  splat(-128), -130048, 130048, -130048};
    tbl[2] = '{"mixed_lane", mixed,       splat(2),    8,       1544,   1544};
    tbl[3] = '{"all_ff",     splat(-1),   splat(-1),   8,       520200, -2040};

    in_rstn = 1'b0; pipe_rstn = 1'b0;
    a_ce = 1'b1; b_ce = 1'b1; p_ce = 1'b1; load = 1'b1;
    din_a = splat(2); din_b = splat(3);

    // Registered outputs stay 0 while reset is held, even with CE active.
    tick(); tick();
    check("rst_pipe", o_pipe, 32'd0);
    check("rst_acc",  o_acc,  32'd0);
    check("rst_acc8", {24'd0, o_acc8}, 32'd0);
    #2;
    in_rstn = 1'b1; pipe_rstn = 1'b1;

    // Combinational vectors, all applied between two clock edges.
    tick();
    for (int i = 0; i < 4; i++) begin
      din_a = tbl[i].a;
      din_b = tbl[i].b;
      #1;
      check({tbl[i].name, "_s"},  o_comb, 32'(tbl[i].exp_s));
      check({tbl[i].name, "_u"},  o_uns,  32'(tbl[i].exp_u));
      check({tbl[i].name, "_ua"}, o_ua,   32'(tbl[i].exp_ua));
    end

    repeat (30) begin
      din_a = {$urandom, $urandom};
      din_b = {$urandom, $urandom};
      #1;
      check("rand_s",  o_comb, 32'(dot(din_a, din_b, 1'b0, 1'b0)));
      check("rand_u",  o_uns,  32'(dot(din_a, din_b, 1'b1, 1'b1)));
      check("rand_ua", o_ua,   32'(dot(din_a, din_b, 1'b1, 1'b0)));
    end

    // Input register + one pipeline stage: two-edge latency, CE hold behaviour.
    tick();
    pulse_reset();
    din_a = splat(2); din_b = splat(3);
    a_ce = 1'b1; b_ce = 1'b1; p_ce = 1'b1;
    tick(); check("pipe_edge1", o_pipe, 32'd0);
    tick(); check("pipe_edge2", o_pipe, 32'd48);
    din_a = splat(1); din_b = splat(1); p_ce = 1'b0;
    tick(); check("pipe_hold1", o_pipe, 32'd48);
    tick(); check("pipe_hold2", o_pipe, 32'd48);
    p_ce = 1'b1; a_ce = 1'b0;
    din_a = splat(5); din_b = splat(4);
    tick(); check("pipe_resume", o_pipe, 32'd8);
    tick(); check("pipe_old_a",  o_pipe, 32'd32);
    a_ce = 1'b1;

    // Accumulator: load then add, reload, then wrap at 2^8.
    pulse_reset();
    din_a = splat(1); din_b = splat(1); p_ce = 1'b1; load = 1'b1;
    tick(); check("acc_load", o_acc, 32'd8); check("acc8_load", {24'd0, o_acc8}, 32'd8);
    load = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("acc_add",  o_acc, 32'(8 * i));
      check("acc8_add", {24'd0, o_acc8}, 32'(8 * i));
    end
    load = 1'b1;
    tick(); check("acc_reload", o_acc, 32'd8);
    din_a = splat(10); din_b = splat(4);
    tick(); check("wrap_load",  o_acc, 32'd320); check("wrap8_load", {24'd0, o_acc8}, 32'd64);
    load = 1'b0;
    tick(); check("wrap_a1", o_acc, 32'd640);  check("wrap8_a1", {24'd0, o_acc8}, 32'd128);
    tick(); check("wrap_a2", o_acc, 32'd960);  check("wrap8_a2", {24'd0, o_acc8}, 32'd192);
    tick(); check("wrap_a3", o_acc, 32'd1280); check("wrap8_a3", {24'd0, o_acc8}, 32'd0);

    // Asynchronous reset mid-accumulation clears without a clock edge.
    din_a = splat(1); din_b = splat(1);
    #2 pipe_rstn = 1'b0;
    #1;
    check("async_rst_acc",  o_acc, 32'd0);
    check("async_rst_acc8", {24'd0, o_acc8}, 32'd0);
    check("async_rst_pipe", o_pipe, 32'd0);
    #1 pipe_rstn = 1'b1;
    tick(); check("restart_acc", o_acc, 32'd8); check("restart_acc8", {24'd0, o_acc8}, 32'd8);

    // Randomised accumulation with random load and CE.
    pulse_reset();
    m = 0;
    repeat (40) begin
      din_a = {$urandom, $urandom};
      din_b = {$urandom, $urandom};
      load  = ($urandom_range(3) == 0);
      p_ce  = ($urandom_range(3) != 0);
      s = dot(din_a, din_b, 1'b0, 1'b0);
      if (p_ce) m = load ? s : m + s;
      tick();
      check("rand_acc",  o_acc, 32'(m));
      check("rand_acc8", {24'd0, o_acc8}, {24'd0, 8'(m)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
